// File: rtl/lcd_dma_axi_reader_pkg.sv
// Shared AXI constants, FSM state type and burst alignment helper for the LCD DMA reader.
package lcd_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } lcd_dma_rd_state_t;

  // Clears the byte-address bits below one full burst so a burst never crosses 4KB.
  function automatic logic [31:0] burst_align_mask(input int unsigned burst_size);
    return ~(32'(burst_size * 4) - 32'd1);
  endfunction

endpackage

// File: rtl/lcd_dma_axi_reader.sv
// LCD DMA burst-read responder: one aligned AXI4 INCR read burst per DMA_START request.
// Optional error status outputs are enabled with LCD_DMA_AXI_READER_ERR_STATUS_EN.
module lcd_dma_axi_reader
  import lcd_dma_pkg::*;
#(
  parameter int unsigned BURST_SIZE = 8,
  parameter logic [3:0]  AXI_CACHE  = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [29:0] DMA_RD_ADDR,
  input  logic        DMA_START,
  output logic        DMA_READY,
  output logic [31:0] DMA_RD_DATA,
  output logic        DMA_RD_DATA_VALID,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
`ifdef LCD_DMA_AXI_READER_ERR_STATUS_EN
  output logic        ERR_STICKY,
  output logic [15:0] ERR_COUNT,
`endif
  output logic        M_AXI_RREADY
);

  localparam logic [31:0] ALIGN_MASK = burst_align_mask(BURST_SIZE);

  lcd_dma_rd_state_t state;

  assign M_AXI_ARLEN   = 8'(BURST_SIZE - 1);
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARCACHE = AXI_CACHE;
  assign M_AXI_ARPROT  = 3'b000;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state             <= IDLE;
      DMA_READY         <= 1'b1;
      DMA_RD_DATA       <= '0;
      DMA_RD_DATA_VALID <= 1'b0;
      M_AXI_ARVALID     <= 1'b0;
      M_AXI_RREADY      <= 1'b0;
      M_AXI_ARADDR      <= '0;
    end else begin
      DMA_RD_DATA_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (DMA_START) begin
            M_AXI_ARADDR  <= {DMA_RD_ADDR, 2'b00} & ALIGN_MASK;
            M_AXI_ARVALID <= 1'b1;
            DMA_READY     <= 1'b0;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          // Error responses are forwarded like any other beat; RLAST alone ends the burst.
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            DMA_RD_DATA       <= M_AXI_RDATA;
            DMA_RD_DATA_VALID <= 1'b1;
            if (M_AXI_RLAST) begin
              M_AXI_RREADY <= 1'b0;
              DMA_READY    <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LCD_DMA_AXI_READER_ERR_STATUS_EN
  localparam int unsigned CNT_W = $clog2(BURST_SIZE) + 1;

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W:0]   beat_num;
  logic             beat_fire;
  logic [1:0]       err_inc;
  logic [16:0]      err_sum;

  // beat_num is one bit wider than the stored count so an over-long burst never aliases BURST_SIZE.
  always_comb begin
    beat_fire = 1'b0;
    beat_num  = {1'b0, beat_cnt} + 1'b1;
    err_inc   = '0;
    err_sum   = '0;
    beat_fire = (state == DATA) && M_AXI_RVALID && M_AXI_RREADY;
    if (beat_fire) begin
      err_inc = 2'(M_AXI_RRESP != AXI_RESP_OKAY)
              + 2'(M_AXI_RLAST && (beat_num != (CNT_W + 1)'(BURST_SIZE)));
    end
    err_sum = {1'b0, ERR_COUNT} + 17'(err_inc);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      beat_cnt   <= '0;
      ERR_COUNT  <= '0;
      ERR_STICKY <= 1'b0;
    end else begin
      if (state == ADDR && M_AXI_ARREADY) begin
        beat_cnt <= '0;
      end else if (beat_fire && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (err_inc != '0) begin
        ERR_COUNT  <= err_sum[16] ? '1 : err_sum[15:0];
        ERR_STICKY <= 1'b1;
      end
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^M_AXI_RRESP;
`endif

endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// Scoreboard bench for lcd_dma_axi_reader: directed plan bursts plus randomized bursts.
module tb_lcd_dma_axi_reader;

  localparam int unsigned BURST = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [29:0] DMA_RD_ADDR;
  logic        DMA_START;
  logic        DMA_READY;
  logic [31:0] DMA_RD_DATA;
  logic        DMA_RD_DATA_VALID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
`ifdef LCD_DMA_AXI_READER_ERR_STATUS_EN
  logic        ERR_STICKY;
  logic [15:0] ERR_COUNT;
`endif

  lcd_dma_axi_reader #(.BURST_SIZE(BURST), .AXI_CACHE(4'b0011)) dut (
    .CLK(CLK), .RESET(RESET),
    .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START), .DMA_READY(DMA_READY),
    .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID),
`ifdef LCD_DMA_AXI_READER_ERR_STATUS_EN
    .ERR_STICKY(ERR_STICKY), .ERR_COUNT(ERR_COUNT),
`endif
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   err_exp = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every word presented by the DUT must match the oldest expected beat, on time.
  always @(negedge CLK) begin
    if (DMA_RD_DATA_VALID === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got data %h expected no word (cycle %0d)", DMA_RD_DATA, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", DMA_RD_DATA, e.data);
        chk("rd_data_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_err();
`ifdef LCD_DMA_AXI_READER_ERR_STATUS_EN
    chk("err_count", 32'(ERR_COUNT), 32'(err_exp > 16'hFFFF ? 16'hFFFF : err_exp));
    chk("err_sticky", 32'(ERR_STICKY), 32'(err_exp != 0));
`endif
  endtask

  // One request; nbeats is where RLAST lands, err_beat gets a non-OKAY RRESP, rst_after>0 aborts.
  task automatic do_burst(input logic [29:0] addr, input int ar_wait, input int gap,
                          input int nbeats, input int err_beat, input int rst_after,
                          input bit seq_data);
    logic [31:0] exp_ar;
    logic [31:0] d;
    exp_ar = ((32'(addr) * 4) / (BURST * 4)) * (BURST * 4);
    chk("ready_before_start", 32'(DMA_READY), 32'd1);
    DMA_RD_ADDR = addr;
    DMA_START   = 1'b1;
    tick();
    DMA_START = 1'b0;
    chk("arvalid_after_start", 32'(M_AXI_ARVALID), 32'd1);
    chk("araddr", M_AXI_ARADDR, exp_ar);
    chk("ready_busy", 32'(DMA_READY), 32'd0);
    chk("arlen", 32'(M_AXI_ARLEN), 32'(BURST - 1));
    for (int w = 0; w < ar_wait; w++) begin
      M_AXI_ARREADY = 1'b0;
      DMA_START     = 1'b1;
      DMA_RD_ADDR   = 30'($urandom);
      tick();
      DMA_START = 1'b0;
      chk("arvalid_hold", 32'(M_AXI_ARVALID), 32'd1);
      chk("araddr_hold", M_AXI_ARADDR, exp_ar);
      chk("rready_in_addr", 32'(M_AXI_RREADY), 32'd0);
    end
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    chk("arvalid_after_hs", 32'(M_AXI_ARVALID), 32'd0);
    chk("rready_in_data", 32'(M_AXI_RREADY), 32'd1);
    for (int i = 0; i < nbeats; i++) begin
      for (int g = 0; g < gap; g++) begin
        M_AXI_RVALID = 1'b0;
        tick();
        chk("rready_gap", 32'(M_AXI_RREADY), 32'd1);
      end
      d = seq_data ? 32'(i + 1) : $urandom;
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = d;
      M_AXI_RRESP  = (i == err_beat) ? 2'($urandom_range(1, 3)) : 2'b00;
      M_AXI_RLAST  = (i == nbeats - 1);
      q.push_back('{data: d, due: cyc + 1});
      if (M_AXI_RRESP != 2'b00) err_exp++;
      if (i == nbeats - 1 && nbeats != BURST) err_exp++;
      if (i == nbeats - 1) begin
        DMA_START   = 1'b1;
        DMA_RD_ADDR = 30'($urandom);
      end
      tick();
      if (rst_after == i + 1) begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        RESET        = 1'b1;
        tick();
        RESET   = 1'b0;
        err_exp = 0;
        chk("rst_ready", 32'(DMA_READY), 32'd1);
        chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        chk("rst_rready", 32'(M_AXI_RREADY), 32'd0);
        chk("rst_valid", 32'(DMA_RD_DATA_VALID), 32'd0);
        chk("rst_pending", 32'(q.size()), 32'd0);
        chk_err();
        return;
      end
    end
    DMA_START    = 1'b0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
    chk("rready_after_last", 32'(M_AXI_RREADY), 32'd0);
    chk("start_on_last_ignored", 32'(M_AXI_ARVALID), 32'd0);
    tick();
    chk("ready_after_burst", 32'(DMA_READY), 32'd1);
    chk("words_forwarded", 32'(q.size()), 32'd0);
    chk("arvalid_idle", 32'(M_AXI_ARVALID), 32'd0);
    chk_err();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1;
    DMA_RD_ADDR = '0;
    DMA_START = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00;
    M_AXI_RLAST = 1'b0;
    M_AXI_RVALID = 1'b0;
    repeat (3) tick();
    chk("reset_ready", 32'(DMA_READY), 32'd1);
    chk("reset_valid", 32'(DMA_RD_DATA_VALID), 32'd0);
    chk("reset_data", DMA_RD_DATA, 32'd0);
    chk("reset_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("reset_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("reset_araddr", M_AXI_ARADDR, 32'd0);
    chk("arsize", 32'(M_AXI_ARSIZE), 32'd2);
    chk("arburst", 32'(M_AXI_ARBURST), 32'd1);
    chk("arcache", 32'(M_AXI_ARCACHE), 32'd3);
    chk("arprot", 32'(M_AXI_ARPROT), 32'd0);
    chk_err();
    RESET = 1'b0;
    tick();

    do_burst(30'h0400_0000, 0, 0, 8, -1, 0, 1'b1);
    do_burst(30'($urandom), 5, 0, 8, -1, 0, 1'b0);
    do_burst(30'h0000_0013, 0, 0, 8, -1, 0, 1'b0);
    do_burst(30'($urandom), 1, 2, 8, 3, 0, 1'b0);
    do_burst(30'($urandom), 0, 0, 8, -1, 3, 1'b0);
    do_burst(30'($urandom), 0, 0, 8, -1, 0, 1'b0);
    do_burst(30'($urandom), 0, 1, 6, -1, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      do_burst(30'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 8,
               int'($urandom_range(0, 11)), 0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
